// File: rtl/pic_host_bus_master_if.sv
// Command-side handshake and 8259A CPU-bus pins of the host bus initiator.
// The master modport is the initiator; slave is the command source / PIC side.
interface pic_host_bus_master_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic       cmd_a0;
   logic [7:0] cmd_data;
   logic [7:0] icw1;
   logic [7:0] icw2;
   logic [7:0] icw3;
   logic [7:0] icw4;
   logic [7:0] data_in;
   logic       CS_bar;
   logic       RD_bar;
   logic       WR_bar;
   logic       A0;
   logic [7:0] data_out;
   logic       data_oe;
   logic       done;
   logic [7:0] rd_data;

   modport master (
      input  cmd_valid, cmd_op, cmd_a0, cmd_data, icw1, icw2, icw3, icw4, data_in,
      output cmd_ready, CS_bar, RD_bar, WR_bar, A0, data_out, data_oe, done, rd_data
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_a0, cmd_data, icw1, icw2, icw3, icw4, data_in,
      input  cmd_ready, CS_bar, RD_bar, WR_bar, A0, data_out, data_oe, done, rd_data
   );
endinterface

// File: rtl/pic_host_bus_master.sv
// Host-side 8259A bus initiator: timed write/read cycles and the ICW1-ICW4
// init sequence, with ICW3/ICW4 skipped according to ICW1 SNGL/IC4 bits.
module pic_host_bus_master #(
   parameter int SETUP_CYC = 1,
   parameter int PULSE_CYC = 2,
   parameter int HOLD_CYC  = 1
) (
   input logic                   clk,
   input logic                   reset,
   pic_host_bus_master_if.master bus
);

   localparam logic [1:0] OP_INIT = 2'b00;
   localparam logic [1:0] OP_READ = 2'b10;
   localparam logic [1:0] OP_NOP  = 2'b11;

   localparam logic [3:0] SETUP_LOAD = 4'(SETUP_CYC - 1);
   localparam logic [3:0] PULSE_LOAD = 4'(PULSE_CYC - 1);
   localparam logic [3:0] HOLD_LOAD  = 4'(HOLD_CYC - 1);

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, GAP} state_t;

   state_t     state;
   state_t     state_next;
   logic [3:0] cnt;
   logic       is_read;
   logic [3:1] pending;
   logic [7:0] icw2_q;
   logic [7:0] icw3_q;
   logic [7:0] icw4_q;
   logic       a0_q;
   logic [7:0] data_q;
   logic [7:0] rd_q;
   logic       accept;
   logic       cnt_zero;
   logic       more_words;
   logic       on_bus;
   logic [1:0] next_idx;
   logic [7:0] next_word;

   assign cnt_zero   = (cnt == 4'd0);
   assign more_words = |pending;
   assign on_bus     = (state == SETUP) || (state == STROBE) || (state == HOLD);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.cmd_valid) begin
               accept     = 1'b1;
               state_next = (bus.cmd_op == OP_NOP) ? GAP : SETUP;
            end
         end
         SETUP:   if (cnt_zero) state_next = STROBE;
         STROBE:  if (cnt_zero) state_next = HOLD;
         HOLD:    if (cnt_zero) state_next = GAP;
         GAP:     state_next = more_words ? SETUP : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Remaining INIT words are issued lowest index first: ICW2, ICW3, ICW4.
   always_comb begin
      next_idx  = 2'd3;
      next_word = icw4_q;
      if (pending[1]) begin
         next_idx  = 2'd1;
         next_word = icw2_q;
      end else if (pending[2]) begin
         next_idx  = 2'd2;
         next_word = icw3_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= 4'd0;
         is_read <= 1'b0;
         pending <= '0;
         icw2_q  <= 8'h00;
         icw3_q  <= 8'h00;
         icw4_q  <= 8'h00;
         a0_q    <= 1'b0;
         data_q  <= 8'h00;
         rd_q    <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  is_read <= (bus.cmd_op == OP_READ);
                  cnt     <= SETUP_LOAD;
                  if (bus.cmd_op == OP_INIT) begin
                     a0_q    <= 1'b0;
                     data_q  <= bus.icw1 | 8'h10;
                     pending <= {bus.icw1[0], ~bus.icw1[1], 1'b1};
                     icw2_q  <= bus.icw2;
                     icw3_q  <= bus.icw3;
                     icw4_q  <= bus.icw4;
                  end else begin
                     pending <= '0;
                     if (bus.cmd_op != OP_NOP) a0_q <= bus.cmd_a0;
                     if (bus.cmd_op == 2'b01) data_q <= bus.cmd_data;
                  end
               end
            end
            SETUP: cnt <= cnt_zero ? PULSE_LOAD : cnt - 4'd1;
            STROBE: begin
               if (cnt_zero) begin
                  cnt <= HOLD_LOAD;
                  if (is_read) rd_q <= bus.data_in;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            HOLD: if (!cnt_zero) cnt <= cnt - 4'd1;
            GAP: begin
               if (more_words) begin
                  pending[next_idx] <= 1'b0;
                  a0_q              <= 1'b1;
                  data_q            <= next_word;
                  cnt               <= SETUP_LOAD;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.cmd_ready = (state == IDLE) && !reset;
   assign bus.CS_bar    = !on_bus;
   assign bus.WR_bar    = !((state == STROBE) && !is_read);
   assign bus.RD_bar    = !((state == STROBE) && is_read);
   assign bus.data_oe   = on_bus && !is_read;
   assign bus.done      = (state == GAP) && !more_words;
   assign bus.A0        = a0_q;
   assign bus.data_out  = data_q;
   assign bus.rd_data   = rd_q;

endmodule

// File: tb/tb_pic_host_bus_master.sv
// Directed bench for pic_host_bus_master: a default-timing instance and a
// SETUP=2/PULSE=4 instance, checked cycle by cycle against a timing model.
module tb_pic_host_bus_master;

   logic       clk = 1'b0;
   logic       reset;
   logic       sel;
   logic       cmd_valid;
   logic [1:0] cmd_op;
   logic       cmd_a0;
   logic [7:0] cmd_data;
   logic [7:0] icw1, icw2, icw3, icw4;
   logic [7:0] data_in;

   logic       mon_cs, mon_rd, mon_wr, mon_a0, mon_oe, mon_done, mon_ready;
   logic [7:0] mon_dout, mon_rd_data;

   int checks = 0;
   int errors = 0;
   int exp_a0 [4];
   int exp_data [4];

   always #5 clk = ~clk;

   pic_host_bus_master_if b ();
   pic_host_bus_master_if b2 ();

   assign b.cmd_valid  = cmd_valid & ~sel;
   assign b.cmd_op     = cmd_op;
   assign b.cmd_a0     = cmd_a0;
   assign b.cmd_data   = cmd_data;
   assign b.icw1       = icw1;
   assign b.icw2       = icw2;
   assign b.icw3       = icw3;
   assign b.icw4       = icw4;
   assign b.data_in    = data_in;
   assign b2.cmd_valid = cmd_valid & sel;
   assign b2.cmd_op    = cmd_op;
   assign b2.cmd_a0    = cmd_a0;
   assign b2.cmd_data  = cmd_data;
   assign b2.icw1      = icw1;
   assign b2.icw2      = icw2;
   assign b2.icw3      = icw3;
   assign b2.icw4      = icw4;
   assign b2.data_in   = data_in;

   pic_host_bus_master dut (
      .clk   (clk),
      .reset (reset),
      .bus   (b)
   );

   pic_host_bus_master #(
      .SETUP_CYC (2),
      .PULSE_CYC (4),
      .HOLD_CYC  (1)
   ) dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (b2)
   );

   assign mon_cs      = sel ? b2.CS_bar    : b.CS_bar;
   assign mon_rd      = sel ? b2.RD_bar    : b.RD_bar;
   assign mon_wr      = sel ? b2.WR_bar    : b.WR_bar;
   assign mon_a0      = sel ? b2.A0        : b.A0;
   assign mon_oe      = sel ? b2.data_oe   : b.data_oe;
   assign mon_done    = sel ? b2.done      : b.done;
   assign mon_ready   = sel ? b2.cmd_ready : b.cmd_ready;
   assign mon_dout    = sel ? b2.data_out  : b.data_out;
   assign mon_rd_data = sel ? b2.rd_data   : b.rd_data;

   task automatic check_output(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic apply_stimulus(input logic [1:0] op, input logic a0, input logic [7:0] data,
                                 input bit hold);
      @(negedge clk);
      check_output("accept_ready", int'(mon_ready), 1);
      cmd_op    = op;
      cmd_a0    = a0;
      cmd_data  = data;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) cmd_valid = 1'b0;
   endtask

   // Expected pins for cycle k after accept: word = (k-1)/W, pos = (k-1)%W.
   task automatic trace_cmd(input string tag, input int n, input bit rd,
                            input int s, input int pl, input int h);
      int w, done_k, pos, word;
      bit act, stb;
      w      = s + pl + h + 1;
      done_k = (n == 0) ? 1 : n * w;
      for (int k = 1; k <= done_k + 1; k++) begin
         @(negedge clk);
         pos  = (k - 1) % w;
         word = (k - 1) / w;
         act  = (k <= n * w) && (pos < s + pl + h);
         stb  = act && (pos >= s) && (pos < s + pl);
         if (rd) data_in = stb ? 8'h3C : 8'hFF;
         check_output($sformatf("%s cs c%0d", tag, k),    int'(mon_cs),    int'(!act));
         check_output($sformatf("%s wr c%0d", tag, k),    int'(mon_wr),    int'(!(stb && !rd)));
         check_output($sformatf("%s rd c%0d", tag, k),    int'(mon_rd),    int'(!(stb && rd)));
         check_output($sformatf("%s oe c%0d", tag, k),    int'(mon_oe),    int'(act && !rd));
         check_output($sformatf("%s done c%0d", tag, k),  int'(mon_done),  int'(k == done_k));
         check_output($sformatf("%s ready c%0d", tag, k), int'(mon_ready), int'(k == done_k + 1));
         if (act) begin
            check_output($sformatf("%s a0 c%0d", tag, k), int'(mon_a0), exp_a0[word]);
            if (!rd) check_output($sformatf("%s data c%0d", tag, k), int'(mon_dout), exp_data[word]);
         end
         if (rd && k >= done_k) check_output($sformatf("%s rd_data c%0d", tag, k), int'(mon_rd_data), 'h3C);
      end
   endtask

   initial begin
      sel       = 1'b0;
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'b11;
      cmd_a0    = 1'b0;
      cmd_data  = 8'h00;
      icw1      = 8'h00;
      icw2      = 8'h00;
      icw3      = 8'h00;
      icw4      = 8'h00;
      data_in   = 8'hFF;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check_output("rst cs",      int'(mon_cs),      1);
      check_output("rst rd",      int'(mon_rd),      1);
      check_output("rst wr",      int'(mon_wr),      1);
      check_output("rst a0",      int'(mon_a0),      0);
      check_output("rst dout",    int'(mon_dout),    0);
      check_output("rst oe",      int'(mon_oe),      0);
      check_output("rst done",    int'(mon_done),    0);
      check_output("rst rd_data", int'(mon_rd_data), 0);
      check_output("rst ready",   int'(mon_ready),   0);
      reset = 1'b0;
      @(negedge clk);
      check_output("post_rst ready", int'(mon_ready), 1);

      exp_a0[0] = 1; exp_data[0] = 'hA5;
      apply_stimulus(2'b01, 1'b1, 8'hA5, 1'b0);
      trace_cmd("wr", 1, 1'b0, 1, 2, 1);

      icw1 = 8'h13; icw2 = 8'h20; icw3 = 8'h00; icw4 = 8'h01;
      exp_a0[0] = 0; exp_data[0] = 'h13;
      exp_a0[1] = 1; exp_data[1] = 'h20;
      exp_a0[2] = 1; exp_data[2] = 'h01;
      apply_stimulus(2'b00, 1'b0, 8'h00, 1'b0);
      trace_cmd("init_sngl_ic4", 3, 1'b0, 1, 2, 1);

      icw1 = 8'h00; icw2 = 8'h08; icw3 = 8'h04; icw4 = 8'h55;
      exp_a0[0] = 0; exp_data[0] = 'h10;
      exp_a0[1] = 1; exp_data[1] = 'h08;
      exp_a0[2] = 1; exp_data[2] = 'h04;
      apply_stimulus(2'b00, 1'b0, 8'h00, 1'b0);
      trace_cmd("init_cascade", 3, 1'b0, 1, 2, 1);

      icw1 = 8'h13;
      apply_stimulus(2'b00, 1'b0, 8'h00, 1'b0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_output("abort cs",    int'(mon_cs),    1);
      check_output("abort wr",    int'(mon_wr),    1);
      check_output("abort rd",    int'(mon_rd),    1);
      check_output("abort a0",    int'(mon_a0),    0);
      check_output("abort dout",  int'(mon_dout),  0);
      check_output("abort oe",    int'(mon_oe),    0);
      check_output("abort done",  int'(mon_done),  0);
      check_output("abort ready", int'(mon_ready), 0);
      reset = 1'b0;
      @(negedge clk);
      check_output("abort2 done",  int'(mon_done),  0);
      check_output("abort2 cs",    int'(mon_cs),    1);
      check_output("abort2 ready", int'(mon_ready), 1);

      exp_a0[0] = 0; exp_data[0] = 'h5A;
      apply_stimulus(2'b01, 1'b0, 8'h5A, 1'b0);
      trace_cmd("wr_after_abort", 1, 1'b0, 1, 2, 1);

      exp_a0[0] = 0;
      apply_stimulus(2'b10, 1'b0, 8'h77, 1'b0);
      trace_cmd("rd", 1, 1'b1, 1, 2, 1);
      data_in = 8'hFF;

      apply_stimulus(2'b11, 1'b1, 8'h99, 1'b0);
      trace_cmd("nop", 0, 1'b0, 1, 2, 1);
      check_output("nop rd_data kept", int'(mon_rd_data), 'h3C);
      check_output("nop a0 kept",      int'(mon_a0),      0);

      sel = 1'b1;
      exp_a0[0] = 1; exp_data[0] = 'hC3;
      apply_stimulus(2'b01, 1'b1, 8'hC3, 1'b1);
      cmd_a0   = 1'b0;
      cmd_data = 8'h5A;
      trace_cmd("slow_wr1", 1, 1'b0, 2, 4, 1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      exp_a0[0] = 0; exp_data[0] = 'h5A;
      trace_cmd("slow_wr2", 1, 1'b0, 2, 4, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pic_host_bus_master.md
# pic_host_bus_master

Host-side bus initiator that drives the 8259A PIC's CPU bus pins: CS_bar, RD_bar, WR_bar, A0, and the 8-bit data bus. It sits between a simple command interface (valid/ready) and the PIC's bus control logic. It generates correctly timed write and read cycles, including the full ICW1–ICW4 initialization sequence, where ICW3 and ICW4 are skipped automatically based on ICW1 bits. It is the initiator counterpart of the PIC's write-decode and read-buffer logic.

## Interface
- SETUP_CYC, 1: cycles with CS_bar low and A0/data valid before the strobe falls; range 1–15.
- PULSE_CYC, 2: cycles the RD_bar/WR_bar strobe stays low; range 1–15.
- HOLD_CYC, 1: cycles CS_bar stays low with A0/data held after the strobe rises; range 1–15.
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted on an edge where cmd_valid & cmd_ready.
- cmd_op  in  2  00 INIT, 01 WRITE, 10 READ, 11 NOP.
- cmd_a0  in  1  A0 for a WRITE or READ.
- cmd_data  in  8  data for a WRITE.
- icw1, icw2, icw3, icw4  in  8 each  INIT words; sampled at accept.
- data_in  in  8  PIC data bus, read direction.
- CS_bar, RD_bar, WR_bar  out  1 each  PIC bus controls, active low.
- A0  out  1  PIC address line.
- data_out  out  8  value to drive on the PIC data bus.
- data_oe  out  1  data bus drive enable; high only during write bus cycles.
- done  out  1  one-cycle pulse when a command completes.
- rd_data  out  8  last read value; valid when done follows a READ; held until the next READ completes.

## Operation
- States: IDLE, SETUP, STROBE, HOLD, GAP. A 4-bit down-counter sets the length of SETUP, STROBE and HOLD. A word index and a remaining-word mask control INIT sequencing.
- **Accept:** cmd_op, cmd_a0 and cmd_data are latched at accept; icw1–icw4 are latched if the op is INIT. While not in IDLE, cmd_valid is ignored.
- **WRITE:** one bus cycle with A0=cmd_a0 and data_out=cmd_data.
- **READ:** one bus cycle with A0=cmd_a0. rd_data captures data_in on the edge that ends the last STROBE cycle.
- **INIT:** the words are issued in this order.
  - ICW1: A0=0, data = icw1 with bit 4 forced to 1.
  - ICW2: A0=1.
  - ICW3: A0=1, issued only if icw1[1]=0 (cascade).
  - ICW4: A0=1, issued only if icw1[0]=1 (IC4).
- **NOP:** no bus activity; done pulses the cycle after accept.
- **Per-word bus cycle:**
  - SETUP: CS_bar=0, A0 valid, data_oe=1 for writes, both strobes high.
  - STROBE: WR_bar=0 (write) or RD_bar=0 (read).
  - HOLD: strobes high, CS_bar, A0 and data unchanged.
  - GAP: 1 cycle with CS_bar=1 and data_oe=0. GAP then moves to SETUP of the next word, or pulses done and moves to IDLE.
- **Invariants:**
  - RD_bar and WR_bar are never both low.
  - A strobe is never low while CS_bar=1.
  - data_oe=0 whenever RD_bar=0.
  - A0 and data_out do not change while CS_bar=0.

## Timing
- **Reset values:** CS_bar=1, RD_bar=1, WR_bar=1, A0=0, data_out=0, data_oe=0, done=0, rd_data=0, state IDLE. cmd_ready is 0 while reset is asserted and 1 in the first cycle after reset deasserts.
- **Reset mid-operation:** at the next edge the bus returns to idle values and the command is aborted. No done is issued and rd_data is unchanged by the aborted cycle.
- **Per-word length:** W = SETUP_CYC + PULSE_CYC + HOLD_CYC + 1 cycles. With defaults W = 5.
- **Latency from accept edge:** done pulses in cycle N·W, where N is the word count (1 for WRITE/READ, 2–4 for INIT). cmd_ready rises in cycle N·W + 1.
- **Default WRITE:**
  - cycles 1–4: CS_bar=0.
  - cycles 2–3: WR_bar=0.
  - cycle 5: done.
  - cycle 6: cmd_ready.
- **Back-to-back commands:** a new command can be accepted in the first IDLE cycle. CS_bar therefore stays high for at least 2 cycles between commands, and for exactly 1 cycle between INIT words.

## Test plan
- Reset, then WRITE a0=1 data=0xA5 (defaults) → CS_bar low cycles 1–4, WR_bar low cycles 2–3, A0=1, data_out=0xA5 with data_oe=1 cycles 1–4, done in cycle 5.
- INIT icw1=0x13, icw2=0x20, icw3=0x00, icw4=0x01 → 3 WR pulses carrying 0x13 (A0=0), 0x20 (A0=1), 0x01 (A0=1); ICW3 skipped; done in cycle 15.
- INIT icw1=0x00 → ICW1 issued as 0x10, then ICW2 and ICW3; ICW4 skipped; done in cycle 15.
- READ a0=0 with data_in=0x3C during STROBE, changed to 0xFF afterwards → rd_data=0x3C at done; RD_bar low cycles 2–3; data_oe=0 throughout.
- Assert reset in cycle 3 of an INIT → the next cycle shows idle bus values, no done; a fresh WRITE afterwards completes normally.
- PULSE_CYC=4, SETUP_CYC=2, cmd_valid held high during a WRITE → a second command is not accepted until cmd_ready; done in cycle 8.
